// File: rtl/calc_num_entry.sv
// rtl/calc_num_entry.sv - calculator operand-entry accumulator and its shared calc_pkg types
package calc_pkg;
  localparam int NumDigits = 8;

  typedef enum logic [4:0] {
    B_NONE       = 5'd0,
    B_NUM_0      = 5'd1,
    B_NUM_1      = 5'd2,
    B_NUM_2      = 5'd3,
    B_NUM_3      = 5'd4,
    B_NUM_4      = 5'd5,
    B_NUM_5      = 5'd6,
    B_NUM_6      = 5'd7,
    B_NUM_7      = 5'd8,
    B_NUM_8      = 5'd9,
    B_NUM_9      = 5'd10,
    B_DOT        = 5'd11,
    B_OP_ADD     = 5'd12,
    B_OP_SUB     = 5'd13,
    B_OP_MUL     = 5'd14,
    B_OP_DIV     = 5'd15,
    B_OP_EQ      = 5'd16,
    B_OP_PERCENT = 5'd17,
    B_OP_SQRT    = 5'd18,
    B_CLEAR      = 5'd19,
    B_MEM_ADD    = 5'd20,
    B_MEM_SUB    = 5'd21,
    B_MEM_RECALL = 5'd22,
    B_MEM_CLEAR  = 5'd23,
    B_UNKNOWN    = 5'd31
  } active_button_t;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_ADD     = 3'd1,
    OP_SUB     = 3'd2,
    OP_MUL     = 3'd3,
    OP_DIV     = 3'd4,
    OP_PERCENT = 3'd5,
    OP_SQRT    = 3'd6
  } op_t;

  // Value = significand[7].significand[6..0] x 10^exponent
  typedef struct packed {
    logic                       sign;
    logic                       error;
    logic [3:0]                 exponent;
    logic [NumDigits-1:0][3:0]  significand;
  } num_t;

  function automatic op_t button2op(input active_button_t b);
    op_t op;
    case (b)
      B_OP_ADD:     op = OP_ADD;
      B_OP_SUB:     op = OP_SUB;
      B_OP_MUL:     op = OP_MUL;
      B_OP_DIV:     op = OP_DIV;
      B_OP_PERCENT: op = OP_PERCENT;
      B_OP_SQRT:    op = OP_SQRT;
      default:      op = OP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic isEqButton(input active_button_t b);
    return (b == B_OP_EQ);
  endfunction
endpackage

module calc_num_entry
  import calc_pkg::*;
#(
  parameter int NumDigits     = calc_pkg::NumDigits,
  parameter bit CommitOnEmpty = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  active_button_t button_i,
  input  logic           button_valid_i,
  output logic           button_ready_o,
  output num_t           num_o,
  output logic           dot_entered_o,
  output logic           commit_valid_o,
  input  logic           commit_ready_i,
  output op_t            op_o,
  output logic           eq_o
);
  localparam int CntW = $clog2(NumDigits + 1);
  localparam int IdxW = $clog2(NumDigits);
  localparam logic [CntW-1:0] CntMax = CntW'(NumDigits);

  typedef enum logic [1:0] {S_EMPTY, S_INT, S_FRAC, S_COMMIT} state_t;

  state_t          state_q, state_d;
  num_t            num_q, num_d;
  logic [CntW-1:0] count_q, count_d;
  logic            dot_q, dot_d;
  op_t             op_q, op_d;
  logic            eq_q, eq_d;

  logic            is_digit;
  logic            is_commit_key;
  logic [3:0]      digit;
  logic [IdxW-1:0] slot;

  always_comb begin
    is_digit      = (button_i >= B_NUM_0) && (button_i <= B_NUM_9);
    is_commit_key = (button_i >= B_OP_ADD) && (button_i <= B_OP_EQ);
    digit         = 4'(button_i - B_NUM_0);
    // Digits fill from the most significant slot downwards
    slot          = IdxW'(NumDigits - 1 - int'(count_q));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      num_q   <= '0;
      count_q <= '0;
      dot_q   <= 1'b0;
      op_q    <= OP_NONE;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      count_q <= count_d;
      dot_q   <= dot_d;
      op_q    <= op_d;
      eq_q    <= eq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    count_d = count_q;
    dot_d   = dot_q;
    op_d    = op_q;
    eq_d    = eq_q;
    unique case (state_q)
      S_COMMIT: begin
        if (commit_ready_i) begin
          state_d = S_EMPTY;
          num_d   = '0;
          count_d = '0;
          dot_d   = 1'b0;
          op_d    = OP_NONE;
          eq_d    = 1'b0;
        end
      end
      default: begin
        if (button_valid_i) begin
          if (is_digit) begin
            // A zero typed before anything else is a leading zero and is dropped
            if (!(state_q == S_EMPTY && digit == 4'd0) && count_q < CntMax) begin
              num_d.significand[slot] = digit;
              count_d = count_q + CntW'(1);
              if (state_q == S_INT)   num_d.exponent = num_q.exponent + 4'd1;
              if (state_q == S_EMPTY) state_d = S_INT;
            end
          end else if (button_i == B_DOT) begin
            if (state_q == S_EMPTY) begin
              num_d.significand[slot] = 4'd0;
              count_d = CntW'(1);
              dot_d   = 1'b1;
              state_d = S_FRAC;
            end else if (state_q == S_INT) begin
              dot_d   = 1'b1;
              state_d = S_FRAC;
            end
          end else if (button_i == B_CLEAR) begin
            state_d = S_EMPTY;
            num_d   = '0;
            count_d = '0;
            dot_d   = 1'b0;
          end else if (is_commit_key && (state_q != S_EMPTY || CommitOnEmpty)) begin
            op_d    = button2op(button_i);
            eq_d    = isEqButton(button_i);
            state_d = S_COMMIT;
          end
        end
      end
    endcase
  end

  assign button_ready_o = (state_q != S_COMMIT);
  assign commit_valid_o = (state_q == S_COMMIT);
  assign num_o          = num_q;
  assign dot_entered_o  = dot_q;
  assign op_o           = op_q;
  assign eq_o           = eq_q;
endmodule

// File: tb/tb_calc_num_entry.sv
// tb/tb_calc_num_entry.sv - vector table, corner sequences and random model check for calc_num_entry
module tb_calc_num_entry;
  import calc_pkg::*;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  active_button_t button = B_NONE;
  logic           button_valid = 1'b0;
  logic           button_ready;
  num_t           num;
  logic           dot_entered;
  logic           commit_valid;
  logic           commit_ready = 1'b1;
  op_t            op;
  logic           eq;

  int total = 0;
  int bad   = 0;

  calc_num_entry dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .button_i       (button),
    .button_valid_i (button_valid),
    .button_ready_o (button_ready),
    .num_o          (num),
    .dot_entered_o  (dot_entered),
    .commit_valid_o (commit_valid),
    .commit_ready_i (commit_ready),
    .op_o           (op),
    .eq_o           (eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           valid;
    active_button_t btn;
    logic           cready;
    logic [31:0]    sig;
    logic [3:0]     expo;
    logic           dot;
    logic           cv;
    op_t            op;
    logic           eq;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] sig, input logic [3:0] expo,
                         input logic dot, input logic cv, input op_t xop, input logic xeq);
    num_t n;
    n = '0;
    n.exponent = expo;
    n.significand = sig;
    chk({tag, ".num"}, 64'(num), 64'(n));
    chk({tag, ".dot"}, 64'(dot_entered), 64'(dot));
    chk({tag, ".cv"},  64'(commit_valid), 64'(cv));
    chk({tag, ".rdy"}, 64'(button_ready), 64'(!cv));
    chk({tag, ".op"},  64'(op), 64'(xop));
    chk({tag, ".eq"},  64'(eq), 64'(xeq));
  endtask

  task automatic press(input active_button_t b, input logic v, input logic cr);
    button = b;
    button_valid = v;
    commit_ready = cr;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: typed digits in order, how many came before the dot
  int  m_dig[8];
  int  m_cnt, m_intlen;
  bit  m_dot, m_commit, m_eq;
  op_t m_op;

  task automatic model_reset();
    m_cnt = 0; m_intlen = 0; m_dot = 0; m_commit = 0; m_eq = 0; m_op = OP_NONE;
  endtask

  function automatic op_t key_op(input active_button_t b);
    if (b == B_OP_ADD) return OP_ADD;
    if (b == B_OP_SUB) return OP_SUB;
    if (b == B_OP_MUL) return OP_MUL;
    if (b == B_OP_DIV) return OP_DIV;
    return OP_NONE;
  endfunction

  task automatic model_step(input logic v, input active_button_t b, input logic cr);
    int d;
    if (m_commit) begin
      if (cr) model_reset();
    end else if (v) begin
      d = int'(b) - int'(B_NUM_0);
      if (d >= 0 && d <= 9) begin
        if (!(m_cnt == 0 && d == 0) && m_cnt < 8) begin
          m_dig[m_cnt] = d;
          m_cnt++;
          if (!m_dot) m_intlen++;
        end
      end else if (b == B_DOT) begin
        if (m_cnt == 0) begin
          m_dig[0] = 0;
          m_cnt = 1;
        end
        m_dot = 1;
      end else if (b == B_CLEAR) begin
        model_reset();
      end else if (b inside {B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV, B_OP_EQ}) begin
        m_commit = 1;
        m_op = key_op(b);
        m_eq = (b == B_OP_EQ);
      end
    end
  endtask

  function automatic logic [31:0] model_sig();
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < m_cnt; i++) s[31 - 4*i -: 4] = 4'(m_dig[i]);
    return s;
  endfunction

  function automatic active_button_t rand_key();
    int r;
    active_button_t others[7];
    others = '{B_NONE, B_OP_PERCENT, B_OP_SQRT, B_MEM_ADD, B_MEM_RECALL, B_MEM_CLEAR, B_UNKNOWN};
    r = $urandom_range(0, 99);
    if (r < 55) return active_button_t'(5'(int'(B_NUM_0) + $urandom_range(0, 9)));
    if (r < 65) return B_DOT;
    if (r < 77) return active_button_t'(5'(int'(B_OP_ADD) + $urandom_range(0, 4)));
    if (r < 81) return B_CLEAR;
    return others[$urandom_range(0, 6)];
  endfunction

  initial begin
    vecs.push_back('{1, B_NUM_1,  1, 32'h1000_0000, 4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_2,  1, 32'h1200_0000, 4'd1, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_3,  1, 32'h1230_0000, 4'd2, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_DOT,    1, 32'h1230_0000, 4'd2, 1, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_4,  1, 32'h1234_0000, 4'd2, 1, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_5,  1, 32'h1234_5000, 4'd2, 1, 0, OP_NONE, 0});
    vecs.push_back('{1, B_OP_ADD, 1, 32'h1234_5000, 4'd2, 1, 1, OP_ADD,  0});
    vecs.push_back('{0, B_NONE,   1, 32'h0,         4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_DOT,    1, 32'h0,         4'd0, 1, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_0,  1, 32'h0,         4'd0, 1, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_5,  1, 32'h0050_0000, 4'd0, 1, 0, OP_NONE, 0});
    vecs.push_back('{1, B_OP_EQ,  1, 32'h0050_0000, 4'd0, 1, 1, OP_NONE, 1});
    vecs.push_back('{0, B_NONE,   1, 32'h0,         4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_1,  1, 32'h1000_0000, 4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_2,  1, 32'h1200_0000, 4'd1, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_3,  1, 32'h1230_0000, 4'd2, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_4,  1, 32'h1234_0000, 4'd3, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_5,  1, 32'h1234_5000, 4'd4, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_6,  1, 32'h1234_5600, 4'd5, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_7,  1, 32'h1234_5670, 4'd6, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_8,  1, 32'h1234_5678, 4'd7, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_9,  1, 32'h1234_5678, 4'd7, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_0,  1, 32'h1234_5678, 4'd7, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_CLEAR,  1, 32'h0,         4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_0,  1, 32'h0,         4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_0,  1, 32'h0,         4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_7,  1, 32'h7000_0000, 4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_DOT,    1, 32'h7000_0000, 4'd0, 1, 0, OP_NONE, 0});
    vecs.push_back('{1, B_DOT,    1, 32'h7000_0000, 4'd0, 1, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_3,  1, 32'h7300_0000, 4'd0, 1, 0, OP_NONE, 0});
    vecs.push_back('{1, B_CLEAR,  1, 32'h0,         4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_NUM_4,  1, 32'h4000_0000, 4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_MEM_RECALL, 1, 32'h4000_0000, 4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_OP_PERCENT, 1, 32'h4000_0000, 4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_UNKNOWN,    1, 32'h4000_0000, 4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_CLEAR,  1, 32'h0,         4'd0, 0, 0, OP_NONE, 0});
    vecs.push_back('{1, B_OP_SUB, 1, 32'h0,         4'd0, 0, 1, OP_SUB,  0});
    vecs.push_back('{0, B_NONE,   1, 32'h0,         4'd0, 0, 0, OP_NONE, 0});

    repeat (2) @(negedge clk);
    chk_all("reset", 32'h0, 4'd0, 0, 0, OP_NONE, 0);
    rst_ni = 1'b1;
    press(B_NONE, 0, 1);
    chk_all("post_reset", 32'h0, 4'd0, 0, 0, OP_NONE, 0);

    foreach (vecs[k]) begin
      press(vecs[k].btn, vecs[k].valid, vecs[k].cready);
      chk_all($sformatf("vec%0d", k), vecs[k].sig, vecs[k].expo, vecs[k].dot,
              vecs[k].cv, vecs[k].op, vecs[k].eq);
    end

    // Commit back-pressure while CLEAR is offered
    press(B_NUM_9, 1, 1);
    press(B_OP_MUL, 1, 1);
    chk_all("t5_commit", 32'h9000_0000, 4'd0, 0, 1, OP_MUL, 0);
    for (int i = 0; i < 3; i++) begin
      press(B_CLEAR, 1, 0);
      chk_all($sformatf("t5_hold%0d", i), 32'h9000_0000, 4'd0, 0, 1, OP_MUL, 0);
    end
    press(B_CLEAR, 1, 1);
    chk_all("t5_done", 32'h0, 4'd0, 0, 0, OP_NONE, 0);
    press(B_CLEAR, 1, 1);
    chk_all("t5_clear", 32'h0, 4'd0, 0, 0, OP_NONE, 0);

    // Asynchronous reset in the middle of entry
    press(B_NUM_4, 1, 1);
    press(B_NUM_2, 1, 1);
    chk_all("t6_entry", 32'h4200_0000, 4'd1, 0, 0, OP_NONE, 0);
    button_valid = 1'b0;
    #2 rst_ni = 1'b0;
    #1 chk_all("t6_async", 32'h0, 4'd0, 0, 0, OP_NONE, 0);
    @(posedge clk);
    #1 chk_all("t6_held", 32'h0, 4'd0, 0, 0, OP_NONE, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    press(B_NUM_5, 1, 1);
    chk_all("t6_restart", 32'h5000_0000, 4'd0, 0, 0, OP_NONE, 0);

    // Randomized run against the reference model
    press(B_NONE, 0, 1);
    rst_ni = 1'b0;
    press(B_NONE, 0, 1);
    rst_ni = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic           v, cr;
      active_button_t b;
      chk_all($sformatf("rnd%0d", c), model_sig(), 4'(m_intlen == 0 ? 0 : m_intlen - 1),
              m_dot, m_commit, m_op, m_eq);
      v  = ($urandom_range(0, 3) != 0);
      cr = ($urandom_range(0, 2) != 0);
      b  = rand_key();
      model_step(v, b, cr);
      press(b, v, cr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
